// File: rtl/sha_ctrl_pkg.sv
// Shared constants and width helpers for the SHA control path (request queue and FSM).
package sha_ctrl_pkg;

    localparam int unsigned ADDRW_DEF = 8;
    localparam int unsigned BYTE_W    = 8;

    // Instruction width for a given address width: two addresses plus two op bits.
    function automatic int unsigned iw_of(input int unsigned addrw);
        return 2 * addrw + 2;
    endfunction

    // Host bytes needed to carry one instruction.
    function automatic int unsigned nb_of(input int unsigned addrw);
        return (iw_of(addrw) + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/sha_sync_fifo.sv
// Show-ahead synchronous FIFO with extended pointers; head reads as zero while empty.
module sha_sync_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer MSB differs only when the write side has lapped the read side.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage carries no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sha_req_queue.sv
// Assembles MSB-first host bytes into SHA instructions and queues them for the control FSM.
// Optional SHA_REQ_QUEUE_FLUSH_EN adds a synchronous flush input.
module sha_req_queue
    import sha_ctrl_pkg::*;
#(
    parameter int unsigned ADDRW = ADDRW_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef SHA_REQ_QUEUE_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic                        req_valid,
    output logic [iw_of(ADDRW)-1:0]     req_data,
    input  logic                        req_ready,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned IW = iw_of(ADDRW);
    localparam int unsigned NB = nb_of(ADDRW);
    localparam int unsigned SW = BYTE_W * NB;
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

`ifndef SHA_REQ_QUEUE_FLUSH_EN
    logic flush;
    assign flush = 1'b0;
`endif

    logic [CW-1:0] byte_cnt;
    logic [SW-1:0] shift_reg;
    logic [SW-1:0] shift_next;
    logic          last_byte;
    logic          accept;
    logic          push;
    logic          fifo_rst;
    logic          fifo_full;
    logic          fifo_empty;

    assign last_byte  = (byte_cnt == CW'(NB - 1));
    assign shift_next = SW'({shift_reg, in_data});

    // Only the completing byte needs a free slot; partial bytes always land.
    assign in_ready = flush || !(last_byte && fifo_full);
    assign accept   = in_valid && in_ready && !flush;
    assign push     = accept && last_byte;
    assign fifo_rst = rst || flush;

    always_ff @(posedge clk) begin
        if (fifo_rst) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (accept) begin
            shift_reg <= shift_next;
            byte_cnt  <= last_byte ? '0 : byte_cnt + CW'(1);
        end
    end

    sha_sync_fifo #(
        .WIDTH (IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (fifo_rst),
        .push  (push),
        .din   (IW'(shift_next)),
        .pop   (req_ready),
        .dout  (req_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign req_valid = !fifo_empty;

endmodule

// File: tb/tb_sha_req_queue.sv
// Self-checking bench for sha_req_queue: directed scenarios plus random traffic against a queue model.
module tb_sha_req_queue;

    localparam int unsigned ADDRW = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 2 * ADDRW + 2;
    localparam int unsigned NB    = (IW + 7) / 8;
    localparam int unsigned CNTW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            req_valid;
    logic [IW-1:0]   req_data;
    logic            req_ready;
    logic [CNTW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IW-1:0] model_q[$];
    int            model_cnt = 0;
    longint        model_acc = 0;

    sha_req_queue #(.ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SHA_REQ_QUEUE_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs after the edge.
    task automatic cyc(input bit iv, input logic [7:0] d, input bit rr, input bit rs, input bit fl);
        bit            full;
        bit            rdy;
        bit            acc;
        logic [IW-1:0] item;
        in_valid  = iv;
        in_data   = d;
        req_ready = rr;
        rst       = rs;
        flush     = fl;
        #1;
        full = (model_q.size() == DEPTH);
        rdy  = fl || !(model_cnt == NB - 1 && full);
        if (!rs) check("in_ready", 32'(in_ready), 32'(rdy));
        @(posedge clk);
        if (rs || fl) begin
            model_q.delete();
            model_cnt = 0;
            model_acc = 0;
        end else begin
            acc = iv && rdy;
            if (rr && model_q.size() > 0) void'(model_q.pop_front());
            if (acc) begin
                if (model_cnt == NB - 1) begin
                    item = IW'((model_acc << 8) | longint'(d));
                    model_q.push_back(item);
                    model_cnt = 0;
                    model_acc = 0;
                end else begin
                    model_acc = (model_acc << 8) | longint'(d);
                    model_cnt++;
                end
            end
        end
        #1;
        check("req_valid", 32'(req_valid), 32'(model_q.size() != 0));
        check("count", 32'(count), 32'(model_q.size()));
        check("req_data", 32'(req_data), (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0);
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_once();
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bit rr;
        bit fl;
        // Reset
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_req_data", 32'(req_data), 32'd0);

        // Basic assembly, MSB-first, unused top bits of first byte ignored
        send(8'h02); send(8'hAB);
        check("basic_not_yet", 32'(req_valid), 32'd0);
        send(8'hCD);
        check("basic_head", 32'(req_data), 32'h2ABCD);
        send(8'hFF); send(8'h00); send(8'h11);
        check("basic_cnt2", 32'(count), 32'd2);
        pop_once();
        check("basic_head2", 32'(req_data), 32'h30011);
        check("basic_cnt1", 32'(count), 32'd1);
        pop_once();
        check("basic_empty", 32'(req_valid), 32'd0);

        // Fill to full, then the completing byte stalls until a pop
        for (int i = 0; i < DEPTH * NB; i++) send(8'(i * 17 + 3));
        check("full_cnt", 32'(count), 32'(DEPTH));
        send(8'h01); send(8'h55);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        check("full_stall", 32'(in_ready), 32'd0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("full_reopen", 32'(in_ready), 32'd1);
        check("full_cnt3", 32'(count), 32'(DEPTH - 1));
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        check("full_refill", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH - 1; i++) pop_once();
        check("full_tail", 32'(req_data), 32'h15577);
        pop_once();

        // Simultaneous push and pop at count 1
        send(8'h00); send(8'h0A); send(8'h0B);
        send(8'h02); send(8'hC0);
        cyc(1'b1, 8'hDE, 1'b1, 1'b0, 1'b0);
        check("pp_cnt", 32'(count), 32'd1);
        check("pp_valid", 32'(req_valid), 32'd1);
        check("pp_head", 32'(req_data), 32'h2C0DE);
        pop_once();

        // Dequeue while empty is ignored
        for (int i = 0; i < 3; i++) pop_once();
        check("empty_pop_cnt", 32'(count), 32'd0);
        send(8'h01); send(8'h23); send(8'h45);
        check("empty_pop_head", 32'(req_data), 32'h12345);
        pop_once();

        // Reset mid-instruction discards the partial bytes
        send(8'h01); send(8'h22);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        send(8'h03); send(8'h44); send(8'h55);
        check("midrst_head", 32'(req_data), 32'h34455);
        check("midrst_cnt", 32'(count), 32'd1);
        pop_once();

`ifdef SHA_REQ_QUEUE_FLUSH_EN
        // Flush drops queued entries, the partial instruction and the presented byte
        for (int i = 0; i < 2 * NB; i++) send(8'(i + 1));
        send(8'h3F);
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        check("flush_cnt", 32'(count), 32'd0);
        check("flush_valid", 32'(req_valid), 32'd0);
        send(8'h00); send(8'h12); send(8'h34);
        check("flush_head", 32'(req_data), 32'h01234);
        pop_once();
`endif

        // Random traffic: slow drain first to reach full, then faster drain
        for (int i = 0; i < 3000; i++) begin
            rr = (i < 1500) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
`ifdef SHA_REQ_QUEUE_FLUSH_EN
            fl = ($urandom_range(0, 149) == 0);
`else
            fl = 1'b0;
`endif
            cyc($urandom_range(0, 3) != 0, 8'($urandom), rr, $urandom_range(0, 299) == 0, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha_req_queue.md
Name: sha_req_queue

Overview:
- Upstream neighbour of the SHA control FSM.
- Accepts instruction bytes from the host byte stream and assembles them into full instructions of 2*ADDRW+2 bits.
- Buffers assembled instructions in a show-ahead FIFO and presents them on req_valid/req_data.
- Releases the head entry when the FSM pulses its ready_out, which connects to this block's req_ready.

Parameters:
- ADDRW, 8, address width; instruction width IW = 2*ADDRW+2.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  host byte valid
- in_data  in  8  host instruction byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- req_valid  out  1  head instruction available
- req_data  out  IW  head instruction (show-ahead)
- req_ready  in  1  dequeue pulse from the FSM's ready_out
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- NB = ceil(IW/8) bytes per instruction; NB = 3 for ADDRW=8.
- Byte order is MSB-first. The first byte supplies bits IW-1 down to 8*(NB-1); its unused upper bits are ignored. Each later byte supplies the next 8 bits.
- Assembler:
  - Holds byte_cnt, range 0..NB-1, and a shift register.
  - Each accepted byte shifts in and increments byte_cnt.
  - When the NB-th byte is accepted, the instruction is pushed and byte_cnt wraps to 0.
- in_ready = !(byte_cnt==NB-1 && full).
  - Partial bytes are always accepted.
  - in_ready has no combinational path from req_ready.
- FIFO:
  - Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty, and pointers wrap naturally.
  - req_valid = !empty.
  - req_data = mem[rd_ptr] combinationally; it is stable while req_valid is high and no pop occurs.
- Pop on req_ready && !empty. req_ready while empty is ignored, with no pointer movement.
- Push and pop in the same cycle:
  - Count is unchanged and both pointers advance.
  - When count==1, the new entry appears at the head the following cycle, so req_valid stays high.
- Full: in_ready drops only on the final byte of an instruction. A pop while full re-enables in_ready the next cycle.
- Latency: final byte accepted at edge N → req_valid=1 after edge N when the FIFO was empty.
- count updates on the same edge as the push or pop.
- Reset, including mid-instruction:
  - byte_cnt=0, pointers=0, count=0, req_valid=0, in_ready=1, req_data reads 0.
  - The shift register is cleared; mem contents are don't-care.
  - Any partial instruction is discarded.

Optional Feature:
- Macro: SHA_REQ_QUEUE_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 at an edge acts as reset for byte_cnt, the shift register, the pointers and count.
  - flush has priority over a simultaneous push or pop.
  - A byte presented with flush is dropped; in_ready stays 1 during flush.
- Undefined: the port is absent and behaviour is identical with flush tied to 0.

Decomposition:
- Shared package sha_ctrl_pkg:
  - ADDRW default constant.
  - Function or localparam for instruction width IW(ADDRW).
  - Bytes-per-instruction NB(ADDRW).
  - The FSM also uses these.
- One sub-module, sha_sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports push/din/pop/dout/full/empty/count.
  - Same clock and synchronous reset.
- The assembler and in_ready logic stay in the top level.

Test Plan:
- Basic assembly: after reset, send 0x02,0xAB,0xCD, then 0xFF,0x00,0x11 → head req_data=18'h2ABCD with req_valid=1 one cycle after the last byte; after one req_ready pulse, the head becomes 18'h30011 (upper bits of 0xFF ignored), count goes 2→1, and a second pulse gives req_valid=0 and count=0.
- Fill to full: push 4 instructions with DEPTH=4 → count=4. Send 2 bytes of a fifth → accepted. Third byte → in_ready=0 and the byte is held. Pulse req_ready → in_ready=1 next cycle, the byte is accepted, and count returns to 4.
- Simultaneous push/pop at count=1: the final byte and req_ready land on the same edge → count stays 1 and req_data switches to the new instruction with no req_valid gap.
- Dequeue while empty: req_ready=1 for 3 cycles with no data → count=0 and req_valid=0. The next instruction then returns correctly, showing the pointers did not move.
- Reset mid-instruction: send 0x01,0x22 then assert rst for one cycle, then send 0x03,0x44,0x55 → the single entry is 18'h34455.
- SHA_REQ_QUEUE_FLUSH_EN: 2 entries queued plus 1 partial byte; flush with in_valid=1 → count=0 and req_valid=0. The subsequent 0x00,0x12,0x34 yields 18'h01234.
